// File: rtl/game_state_controller.sv
// game_state_controller: Frogger game-flow FSM tracking lives, level, a timed
// respawn phase, optional pause and the end-of-game hold states.
// Optional feature macro: PAUSE_EN builds the PAUSED state and pause edge
// detection. Without it, i_Pause is ignored.
module game_state_controller #(
    parameter int unsigned C_NB_LIVES        = 3,
    parameter int unsigned C_MAX_LEVEL       = 9,
    parameter int unsigned C_RESPAWN_CYCLES  = 25000000,
    parameter int unsigned C_END_HOLD_CYCLES = 50000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_Has_Collided,
    input  logic       i_Level_Up,
    input  logic       i_Pause,
    output logic       o_Game_Active,
    output logic [2:0] o_State,
    output logic [3:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Respawn,
    output logic       o_Game_Over,
    output logic       o_Win
);

    localparam int unsigned C_MAX_CYC =
        (C_RESPAWN_CYCLES > C_END_HOLD_CYCLES) ? C_RESPAWN_CYCLES : C_END_HOLD_CYCLES;
    localparam int TW = $clog2(C_MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUNNING   = 3'd1,
        RESPAWN   = 3'd2,
        PAUSED    = 3'd3,
        GAME_OVER = 3'd4,
        VICTORY   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      lives_q, lives_d;
    logic [3:0]      level_q, level_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            respawn_q, respawn_d;
    logic            start_dly_q, collide_dly_q;
    logic            start_edge, collide_edge, pause_edge;

`ifdef PAUSE_EN
    logic            pause_dly_q;
    assign pause_edge = i_Pause & ~pause_dly_q;
`else
    logic            unused_pause;
    assign unused_pause = i_Pause;
    assign pause_edge   = 1'b0;
`endif

    assign start_edge   = i_Start & ~start_dly_q;
    assign collide_edge = i_Has_Collided & ~collide_dly_q;

    // Next-state, counter and pulse computation for the game flow
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        timer_d   = timer_q;
        respawn_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d   = RUNNING;
                    lives_d   = 4'(C_NB_LIVES);
                    level_d   = 4'd1;
                    respawn_d = 1'b1;
                end
            end
            RUNNING: begin
                if (collide_edge) begin
                    if (lives_q > 4'd1) begin
                        lives_d = lives_q - 4'd1;
                        timer_d = TW'(C_RESPAWN_CYCLES - 1);
                        state_d = RESPAWN;
                    end else begin
                        lives_d = 4'd0;
                        timer_d = TW'(C_END_HOLD_CYCLES - 1);
                        state_d = GAME_OVER;
                    end
                end else if (i_Level_Up) begin
                    if (level_q < 4'(C_MAX_LEVEL)) begin
                        level_d   = level_q + 4'd1;
                        respawn_d = 1'b1;
                    end else begin
                        timer_d = TW'(C_END_HOLD_CYCLES - 1);
                        state_d = VICTORY;
                    end
                end else if (pause_edge) begin
                    state_d = PAUSED;
                end
            end
            RESPAWN: begin
                if (timer_q == '0) begin
                    state_d   = RUNNING;
                    respawn_d = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
`ifdef PAUSE_EN
            PAUSED: begin
                if (pause_edge) state_d = RUNNING;
            end
`endif
            GAME_OVER, VICTORY: begin
                if (timer_q == '0) state_d = IDLE;
                else               timer_d = timer_q - TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, pulse and input-edge history registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= IDLE;
            lives_q       <= '0;
            level_q       <= '0;
            timer_q       <= '0;
            respawn_q     <= 1'b0;
            start_dly_q   <= 1'b1;
            collide_dly_q <= 1'b1;
`ifdef PAUSE_EN
            pause_dly_q   <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            timer_q       <= timer_d;
            respawn_q     <= respawn_d;
            start_dly_q   <= i_Start;
            collide_dly_q <= i_Has_Collided;
`ifdef PAUSE_EN
            pause_dly_q   <= i_Pause;
`endif
        end
    end

    assign o_State       = state_q;
    assign o_Lives       = lives_q;
    assign o_Level       = level_q;
    assign o_Respawn     = respawn_q;
    assign o_Game_Active = (state_q == RUNNING);
    assign o_Game_Over   = (state_q == GAME_OVER);
    assign o_Win         = (state_q == VICTORY);

endmodule

// File: tb/tb_game_state_controller.sv
// Testbench for game_state_controller: directed scenarios with constant
// expectations plus a randomized run against a cycle-count reference model.
// Pause expectations follow whether PAUSE_EN is defined for the build.
module tb_game_state_controller;

    localparam int NB  = 2;
    localparam int MAX = 3;
    localparam int RC  = 4;
    localparam int EH  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0, i_coll = 1'b0, i_lu = 1'b0, i_pause = 1'b0;
    logic       o_active, o_resp, o_go, o_win;
    logic [2:0] o_state;
    logic [3:0] o_lives, o_level;

    int checks = 0;
    int errors = 0;

    // reference model: game phase with a count of cycles still to spend in it
    int m_state, m_lives, m_level, m_left;
    bit m_resp, prev_s, prev_c, prev_p;

    game_state_controller #(
        .C_NB_LIVES(NB), .C_MAX_LEVEL(MAX),
        .C_RESPAWN_CYCLES(RC), .C_END_HOLD_CYCLES(EH)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(i_start),
        .i_Has_Collided(i_coll), .i_Level_Up(i_lu), .i_Pause(i_pause),
        .o_Game_Active(o_active), .o_State(o_state), .o_Lives(o_lives),
        .o_Level(o_level), .o_Respawn(o_resp), .o_Game_Over(o_go), .o_Win(o_win)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_level = 0; m_left = 0; m_resp = 0;
        prev_s = 1; prev_c = 1; prev_p = 1;
    endtask

    task automatic model_update(input bit s, input bit c, input bit l, input bit p);
        bit se, ce, pe;
        se = s && !prev_s;
        ce = c && !prev_c;
`ifdef PAUSE_EN
        pe = p && !prev_p;
`else
        pe = 0;
`endif
        prev_s = s; prev_c = c; prev_p = p;
        m_resp = 0;
        case (m_state)
            0: if (se) begin m_state = 1; m_lives = NB; m_level = 1; m_resp = 1; end
            1: begin
                if (ce) begin
                    if (m_lives > 1) begin m_lives--; m_state = 2; m_left = RC; end
                    else begin m_lives = 0; m_state = 4; m_left = EH; end
                end else if (l) begin
                    if (m_level < MAX) begin m_level++; m_resp = 1; end
                    else begin m_state = 5; m_left = EH; end
                end else if (pe) m_state = 3;
            end
            2: begin m_left--; if (m_left == 0) begin m_state = 1; m_resp = 1; end end
            3: if (pe) m_state = 1;
            default: begin m_left--; if (m_left == 0) m_state = 0; end
        endcase
    endtask

    // apply inputs, clock once, advance the model, settle 1 time unit
    task automatic step(input bit s, input bit c, input bit l, input bit p);
        i_start = s; i_coll = c; i_lu = l; i_pause = p;
        @(posedge clk);
        model_update(s, c, l, p);
        #1;
    endtask

    task automatic test_reset();
        i_start = 1; rst_n = 0; model_reset();
        #3;
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", o_state); end
        checks++; if (o_lives !== 4'd0 || o_level !== 4'd0) begin errors++; $display("FAIL rst_cnt got lives %0d level %0d exp 0 0", o_lives, o_level); end
        checks++; if ({o_active, o_resp, o_go, o_win} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {o_active, o_resp, o_go, o_win}); end
        @(negedge clk); rst_n = 1;
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL held_start got %0d exp 0", o_state); end
    endtask

    task automatic test_start();
        step(0, 0, 0, 0); step(1, 0, 0, 0);
        checks++; if (o_state !== 3'd1 || o_lives !== 4'd2 || o_level !== 4'd1) begin errors++; $display("FAIL start got st %0d lv %0d lvl %0d exp 1 2 1", o_state, o_lives, o_level); end
        checks++; if (o_resp !== 1'b1 || o_active !== 1'b1) begin errors++; $display("FAIL start_resp got resp %b act %b exp 1 1", o_resp, o_active); end
        step(1, 0, 0, 0);
        checks++; if (o_resp !== 1'b0) begin errors++; $display("FAIL start_pulse got %b exp 0", o_resp); end
    endtask

    task automatic test_collision();
        int inactive = 0;
        step(1, 1, 0, 0);
        checks++; if (o_state !== 3'd2 || o_lives !== 4'd1) begin errors++; $display("FAIL coll got st %0d lv %0d exp 2 1", o_state, o_lives); end
        while (o_active === 1'b0 && inactive < 20) begin inactive++; step(1, 1, 0, 0); end
        checks++; if (inactive != RC) begin errors++; $display("FAIL respawn_len got %0d exp %0d", inactive, RC); end
        checks++; if (o_state !== 3'd1 || o_resp !== 1'b1) begin errors++; $display("FAIL respawn_exit got st %0d resp %b exp 1 1", o_state, o_resp); end
        step(1, 1, 0, 0);
        checks++; if (o_resp !== 1'b0 || o_lives !== 4'd1) begin errors++; $display("FAIL held_coll got resp %b lv %0d exp 0 1", o_resp, o_lives); end
    endtask

    task automatic test_game_over();
        step(1, 0, 0, 0); step(1, 1, 0, 0);
        checks++; if (o_state !== 3'd4 || o_lives !== 4'd0 || o_go !== 1'b1) begin errors++; $display("FAIL gameover got st %0d lv %0d go %b exp 4 0 1", o_state, o_lives, o_go); end
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL go_hold got %0d exp 4", o_state); end
        step(1, 0, 0, 0);
        checks++; if (o_state !== 3'd0 || o_lives !== 4'd0 || o_go !== 1'b0) begin errors++; $display("FAIL go_exit got st %0d lv %0d exp 0 0", o_state, o_lives); end
    endtask

    task automatic test_level_up();
        step(0, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        checks++; if (o_level !== 4'd2 || o_resp !== 1'b1 || o_state !== 3'd1) begin errors++; $display("FAIL lvl2 got lvl %0d resp %b st %0d exp 2 1 1", o_level, o_resp, o_state); end
        step(1, 0, 0, 0); step(1, 0, 1, 0);
        checks++; if (o_level !== 4'd3 || o_resp !== 1'b1) begin errors++; $display("FAIL lvl3 got lvl %0d resp %b exp 3 1", o_level, o_resp); end
        step(1, 0, 0, 0); step(1, 0, 1, 0);
        checks++; if (o_state !== 3'd5 || o_win !== 1'b1 || o_level !== 4'd3 || o_resp !== 1'b0) begin errors++; $display("FAIL victory got st %0d win %b lvl %0d resp %b exp 5 1 3 0", o_state, o_win, o_level, o_resp); end
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        checks++; if (o_state !== 3'd5) begin errors++; $display("FAIL vic_hold got %0d exp 5", o_state); end
        step(1, 0, 0, 0);
        checks++; if (o_state !== 3'd0 || o_level !== 4'd3) begin errors++; $display("FAIL vic_exit got st %0d lvl %0d exp 0 3", o_state, o_level); end
    endtask

    task automatic test_simultaneous();
        step(0, 0, 0, 0); step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        checks++; if (o_state !== 3'd2 || o_lives !== 4'd1 || o_level !== 4'd1) begin errors++; $display("FAIL coll_lu got st %0d lv %0d lvl %0d exp 2 1 1", o_state, o_lives, o_level); end
        for (int i = 0; i < RC; i++) step(1, 0, 0, 0);
        checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL coll_lu_exit got %0d exp 1", o_state); end
    endtask

    task automatic test_pause();
        step(1, 0, 0, 1);
`ifdef PAUSE_EN
        checks++; if (o_state !== 3'd3 || o_active !== 1'b0) begin errors++; $display("FAIL pause_in got st %0d act %b exp 3 0", o_state, o_active); end
        step(1, 1, 0, 1);
        checks++; if (o_state !== 3'd3 || o_lives !== 4'd1) begin errors++; $display("FAIL pause_coll got st %0d lv %0d exp 3 1", o_state, o_lives); end
        step(1, 0, 0, 0); step(1, 0, 0, 1);
        checks++; if (o_state !== 3'd1 || o_lives !== 4'd1 || o_resp !== 1'b0) begin errors++; $display("FAIL pause_out got st %0d lv %0d resp %b exp 1 1 0", o_state, o_lives, o_resp); end
`else
        checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL nopause_1 got %0d exp 1", o_state); end
        step(1, 0, 0, 0); step(1, 0, 0, 1);
        checks++; if (o_state !== 3'd1 || o_lives !== 4'd1) begin errors++; $display("FAIL nopause_2 got st %0d lv %0d exp 1 1", o_state, o_lives); end
`endif
    endtask

    task automatic test_reset_mid();
        #2; rst_n = 0; model_reset();
        #1;
        checks++; if (o_state !== 3'd0 || o_lives !== 4'd0 || o_level !== 4'd0) begin errors++; $display("FAIL mid_rst got st %0d lv %0d lvl %0d exp 0 0 0", o_state, o_lives, o_level); end
        @(negedge clk); rst_n = 1;
        step(1, 0, 0, 0);
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL mid_rst_held got %0d exp 0", o_state); end
        step(0, 0, 0, 0); step(1, 0, 0, 0);
        checks++; if (o_state !== 3'd1 || o_lives !== 4'd2) begin errors++; $display("FAIL mid_rst_restart got st %0d lv %0d exp 1 2", o_state, o_lives); end
    endtask

    task automatic test_random();
        bit s = 1, c = 0, p = 0, l;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) s = ~s;
            if ($urandom_range(0, 5) == 0) c = ~c;
            if ($urandom_range(0, 7) == 0) p = ~p;
            l = ($urandom_range(0, 5) == 0);
            step(s, c, l, p);
            checks++;
            if (o_state !== 3'(m_state) || o_lives !== 4'(m_lives) || o_level !== 4'(m_level) ||
                o_resp !== m_resp || o_active !== (m_state == 1) ||
                o_go !== (m_state == 4) || o_win !== (m_state == 5)) begin
                errors++;
                $display("FAIL rand cyc %0d got st %0d lv %0d lvl %0d resp %b act %b go %b win %b exp st %0d lv %0d lvl %0d resp %b",
                         i, o_state, o_lives, o_level, o_resp, o_active, o_go, o_win,
                         m_state, m_lives, m_level, m_resp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_collision();
        test_game_over();
        test_level_up();
        test_simultaneous();
        test_pause();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
